random_generator: RTL and testbench



---
 rtl/random_generator.sv | 78 +++++++
 tb/tb_random_generator.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/random_generator.sv
// random_generator
//   Free-running pseudo-random source built from one 16-bit maximal-length
//   LFSR (x^16+x^14+x^13+x^11+1) and four independent 4-bit maximal-length
//   LFSRs (x^4+x^3+1). All registers advance on every rising clock edge.
//   There is no enable: after reset the block runs autonomously.
//
// Parameters
//   SEED16 : reset value of the 16-bit LFSR
//   SEED4  : reset values of the four 4-bit lanes, {lane3, lane2, lane1, lane0}
//
// Ports
//   clock        : single clock, rising-edge active
//   nreset       : asynchronous active-low reset (release sampled synchronously)
//   rng_out      : current 16-bit LFSR state (registered)
//   rng_out_4bit : current lane states {lane3, lane2, lane1, lane0} (registered)
module random_generator #(
  parameter logic [15:0] SEED16 = 16'hACE1,
  parameter logic [15:0] SEED4  = 16'hF731
) (
  input  logic        clock,
  input  logic        nreset,
  output logic [15:0] rng_out,
  output logic [15:0] rng_out_4bit
);

  logic [15:0] lfsr16_q;
  logic [15:0] lfsr16_d;
  logic [15:0] lanes_q;
  logic [15:0] lanes_d;

  // Fibonacci shift-left step of the 16-bit LFSR. The all-zero state is
  // the only one the XOR feedback cannot leave, so it is forced to 1.
  function automatic logic [15:0] step16(input logic [15:0] s);
    logic [15:0] r;
    if (s == 16'h0000) begin
      r = 16'h0001;
    end else begin
      r = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    return r;
  endfunction

  // Fibonacci shift-left step of one 4-bit lane, with the same zero guard.
  function automatic logic [3:0] step4(input logic [3:0] s);
    logic [3:0] r;
    if (s == 4'h0) begin
      r = 4'h1;
    end else begin
      r = {s[2:0], s[3] ^ s[2]};
    end
    return r;
  endfunction

  // Next-state computation for the 16-bit LFSR and all four lanes.
  always_comb begin
    lfsr16_d = step16(lfsr16_q);
    lanes_d  = lanes_q;
    for (int i = 0; i < 4; i++) begin
      lanes_d[4*i +: 4] = step4(lanes_q[4*i +: 4]);
    end
  end

  // State registers: seeds are loaded asynchronously while reset is held,
  // so even an illegal zero seed is visible until the first edge after release.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      lfsr16_q <= SEED16;
      lanes_q  <= SEED4;
    end else begin
      lfsr16_q <= lfsr16_d;
      lanes_q  <= lanes_d;
    end
  end

  assign rng_out      = lfsr16_q;
  assign rng_out_4bit = lanes_q;

endmodule

// File: tb/tb_random_generator.sv
module tb_random_generator;

  logic        clock;
  logic        nreset;
  logic [15:0] rng_d;
  logic [15:0] rng4_d;
  logic [15:0] rng_z;
  logic [15:0] rng4_z;
  logic [15:0] rng_o;
  logic [15:0] rng4_o;

  int total;
  int passed;

  // default seeds
  random_generator dut_dflt (
    .clock(clock), .nreset(nreset), .rng_out(rng_d), .rng_out_4bit(rng4_d)
  );

  // illegal zero seeds exercise the lock-up guard
  random_generator #(.SEED16(16'h0000), .SEED4(16'h0000)) dut_zero (
    .clock(clock), .nreset(nreset), .rng_out(rng_z), .rng_out_4bit(rng4_z)
  );

  // seed override
  random_generator #(.SEED16(16'h0001)) dut_one (
    .clock(clock), .nreset(nreset), .rng_out(rng_o), .rng_out_4bit(rng4_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model of x^16+x^14+x^13+x^11+1 written from the polynomial taps.
  function automatic logic [15:0] model16(input logic [15:0] s);
    logic fb;
    if (s == 16'h0000) return 16'h0001;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return (s << 1) | {15'd0, fb};
  endfunction

  // Reference model of four parallel x^4+x^3+1 lanes.
  function automatic logic [15:0] model4(input logic [15:0] s);
    logic [15:0] r;
    logic [3:0]  n;
    r = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      n = s[4*k +: 4];
      if (n == 4'h0) n = 4'h1;
      else n = {n[2:0], n[3] ^ n[2]};
      r[4*k +: 4] = n;
    end
    return r;
  endfunction

  function automatic logic lanes_nonzero(input logic [15:0] s);
    return (s[3:0] != 4'h0) && (s[7:4] != 4'h0) &&
           (s[11:8] != 4'h0) && (s[15:12] != 4'h0);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  logic [15:0] m16;
  logic [15:0] m4;
  int          first_ace1;

  initial begin
    total  = 0;
    passed = 0;
    nreset = 1'b0;

    // Hold reset for several cycles with the clock running.
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("rst_rng",       {16'd0, rng_d},  {16'd0, 16'hACE1});
      check("rst_rng4",      {16'd0, rng4_d}, {16'd0, 16'hF731});
      check("rst_zero_rng",  {16'd0, rng_z},  {16'd0, 16'h0000});
      check("rst_zero_rng4", {16'd0, rng4_z}, {16'd0, 16'h0000});
      check("rst_one_rng",   {16'd0, rng_o},  {16'd0, 16'h0001});
    end
    nreset = 1'b1;

    // First edge after release.
    @(negedge clock);
    check("e1_rng",       {16'd0, rng_d},  {16'd0, 16'h59C3});
    check("e1_rng4",      {16'd0, rng4_d}, {16'd0, 16'hEF62});
    check("e1_zero_rng",  {16'd0, rng_z},  {16'd0, 16'h0001});
    check("e1_zero_rng4", {16'd0, rng4_z}, {16'd0, 16'h1111});
    check("e1_one_rng",   {16'd0, rng_o},  {16'd0, 16'h0002});

    // Second edge.
    @(negedge clock);
    check("e2_rng",       {16'd0, rng_d},  {16'd0, 16'hB387});
    check("e2_rng4",      {16'd0, rng4_d}, {16'd0, 16'hCED4});
    check("e2_zero_rng",  {16'd0, rng_z},  {16'd0, 16'h0002});
    check("e2_zero_rng4", {16'd0, rng4_z}, {16'd0, 16'h2222});
    check("e2_one_rng",   {16'd0, rng_o},  {16'd0, 16'h0004});

    // Model-compare every cycle up to the full 16-bit period.
    m16 = 16'hB387;
    m4  = 16'hCED4;
    first_ace1 = 0;
    for (int n = 3; n <= 65535; n++) begin
      @(negedge clock);
      m16 = model16(m16);
      m4  = model4(m4);
      check("model", {rng_d, rng4_d}, {m16, m4});
      check("nonzero", {30'd0, rng_d != 16'h0000, lanes_nonzero(rng4_d)}, {30'd0, 2'b11});
      if (n <= 25) begin
        check("zero_nonzero", {30'd0, rng_z != 16'h0000, lanes_nonzero(rng4_z)}, {30'd0, 2'b11});
      end
      if ((n % 15) == 0) begin
        check("period4", {16'd0, rng4_d}, {16'd0, 16'hF731});
      end
      if ((rng_d == 16'hACE1) && (first_ace1 == 0)) first_ace1 = n;
    end
    check("period16_end", {16'd0, rng_d}, {16'd0, 16'hACE1});
    check("period16_first", first_ace1, 32'd65535);

    // Asynchronous reset dropped between edges, well into the run.
    @(negedge clock);
    #2 nreset = 1'b0;
    #1;
    check("async_rng",  {16'd0, rng_d},  {16'd0, 16'hACE1});
    check("async_rng4", {16'd0, rng4_d}, {16'd0, 16'hF731});
    @(negedge clock);
    check("hold_rng",  {16'd0, rng_d},  {16'd0, 16'hACE1});
    check("hold_rng4", {16'd0, rng4_d}, {16'd0, 16'hF731});
    nreset = 1'b1;
    @(negedge clock);
    check("rep1_rng",  {16'd0, rng_d},  {16'd0, 16'h59C3});
    check("rep1_rng4", {16'd0, rng4_d}, {16'd0, 16'hEF62});
    @(negedge clock);
    check("rep2_rng",  {16'd0, rng_d},  {16'd0, 16'hB387});
    check("rep2_rng4", {16'd0, rng4_d}, {16'd0, 16'hCED4});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
